// File: rtl/prbs_checker.sv
// PRBS receive checker: slips a local Galois LFSR model into alignment, locks, then counts bit errors.
// Latency: all outputs registered, one cycle after the sampled bit; no backpressure, bits sampled only when bit_valid is high.
module prbs_checker #(
  parameter int              WIDTH      = 4,
  parameter logic [WIDTH-1:0] POLY      = 4'b1101,
  parameter logic [WIDTH-1:0] SEED      = 4'b0001,
  parameter int              LOCK_CNT   = 8,
  parameter int              ERR_WINDOW = 64,
  parameter int              ERR_THRESH = 4,
  parameter int              ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 clear_cnt,
  output logic                 locked,
  output logic                 bit_err,
  output logic                 lock_lost,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam int WC_W = $clog2(ERR_WINDOW + 1);
  localparam int WE_W = $clog2(ERR_THRESH + 1);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_SYNC,
    ST_LOCKED
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_model;
  logic [MC_W-1:0]  r_match_cnt;
  logic [WC_W-1:0]  r_win_cnt;
  logic [WE_W-1:0]  r_win_err;

  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_fb;
  logic [WIDTH-1:0] w_model_nxt;
  logic             w_match;
  logic [MC_W-1:0]  w_mc_inc;
  logic [WC_W-1:0]  w_wc_inc;
  logic [WE_W-1:0]  w_we_inc;
  logic             w_lock_hit;
  logic             w_win_wrap;
  logic             w_lose;
  logic             w_cnt_sat;

  // Same step as the generator; an all-zero result would stall forever, so reseed.
  assign w_shift     = {r_model[WIDTH-2:0], 1'b0};
  assign w_fb        = (POLY[WIDTH-1] == w_shift[WIDTH-1]) ? (POLY ^ w_shift) : w_shift;
  assign w_model_nxt = (w_fb == '0) ? SEED : w_fb;

  assign w_match    = (bit_in == r_model[0]);
  assign w_mc_inc   = r_match_cnt + MC_W'(1);
  assign w_wc_inc   = r_win_cnt + WC_W'(1);
  assign w_we_inc   = r_win_err + WE_W'(1);
  assign w_lock_hit = (w_mc_inc == MC_W'(LOCK_CNT));
  assign w_win_wrap = (w_wc_inc == WC_W'(ERR_WINDOW));
  assign w_lose     = !w_match && (w_we_inc == WE_W'(ERR_THRESH));
  assign w_cnt_sat  = &err_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_HUNT;
      r_model     <= SEED;
      r_match_cnt <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      locked      <= 1'b0;
      bit_err     <= 1'b0;
      lock_lost   <= 1'b0;
      err_count   <= '0;
    end else begin
      bit_err   <= 1'b0;
      lock_lost <= 1'b0;

      // Clear wins over a same-cycle increment.
      if (clear_cnt) begin
        err_count <= '0;
      end else if (bit_valid && (r_state == ST_LOCKED) && !w_match && !w_cnt_sat) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end

      if (bit_valid) begin
        case (r_state)
          ST_HUNT: begin
            if (w_match) begin
              r_model     <= w_model_nxt;
              r_match_cnt <= MC_W'(1);
              r_state     <= ST_SYNC;
            end
          end
          ST_SYNC: begin
            if (w_match) begin
              r_model     <= w_model_nxt;
              r_match_cnt <= w_mc_inc;
              if (w_lock_hit) begin
                r_state   <= ST_LOCKED;
                locked    <= 1'b1;
                r_win_cnt <= '0;
                r_win_err <= '0;
              end
            end else begin
              r_match_cnt <= '0;
              r_state     <= ST_HUNT;
            end
          end
          ST_LOCKED: begin
            // Once locked the model free-runs; errors never slip it.
            r_model <= w_model_nxt;
            if (!w_match) begin
              bit_err <= 1'b1;
            end
            if (w_lose) begin
              r_state     <= ST_HUNT;
              r_match_cnt <= '0;
              locked      <= 1'b0;
              lock_lost   <= 1'b1;
            end else if (w_win_wrap) begin
              r_win_cnt <= '0;
              r_win_err <= '0;
            end else begin
              r_win_cnt <= w_wc_inc;
              if (!w_match) begin
                r_win_err <= w_we_inc;
              end
            end
          end
          default: begin
            r_state     <= ST_HUNT;
            r_match_cnt <= '0;
            locked      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: reference model indexes the period-7 bit table rather than running an LFSR.
module tb_prbs_checker;

  localparam int CW         = 16;
  localparam int LOCK_CNT   = 8;
  localparam int ERR_WINDOW = 64;
  localparam int ERR_THRESH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          bit_valid;
  logic          bit_in;
  logic          clear_cnt;
  logic          locked;
  logic          bit_err;
  logic          lock_lost;
  logic [CW-1:0] err_count;

  prbs_checker dut (
    .clk       (clk),
    .reset     (reset),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .bit_err   (bit_err),
    .lock_lost (lock_lost),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          lk;
    logic          be;
    logic          ll;
    logic [CW-1:0] ec;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Generator output for states 1,2,4,5,7,3,6.
  logic [0:6] seqb = 7'b1001110;

  int            m_st;
  int            m_idx;
  int            m_mc;
  int            m_wc;
  int            m_we;
  logic [CW-1:0] m_ec;
  int            gen_idx;

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (locked !== mon_e.lk) begin
        failures++;
        $display("FAIL sb_locked t=%0t got=%b exp=%b", $time, locked, mon_e.lk);
      end
      checks++;
      if (bit_err !== mon_e.be) begin
        failures++;
        $display("FAIL sb_bit_err t=%0t got=%b exp=%b", $time, bit_err, mon_e.be);
      end
      checks++;
      if (lock_lost !== mon_e.ll) begin
        failures++;
        $display("FAIL sb_lock_lost t=%0t got=%b exp=%b", $time, lock_lost, mon_e.ll);
      end
      checks++;
      if (err_count !== mon_e.ec) begin
        failures++;
        $display("FAIL sb_err_count t=%0t got=%0d exp=%0d", $time, err_count, mon_e.ec);
      end
    end
  end

  task automatic mdl_reset();
    m_st = 0; m_idx = 0; m_mc = 0; m_wc = 0; m_we = 0; m_ec = '0;
  endtask

  task automatic cyc(input logic v, input logic b, input logic clr);
    exp_t e;
    logic be;
    logic ll;
    logic expb;
    be = 1'b0;
    ll = 1'b0;
    @(negedge clk);
    bit_valid = v;
    bit_in    = b;
    clear_cnt = clr;
    if (v) begin
      expb = seqb[m_idx];
      case (m_st)
        0: if (b == expb) begin
          m_idx = (m_idx + 1) % 7; m_mc = 1; m_st = 1;
        end
        1: if (b == expb) begin
          m_idx = (m_idx + 1) % 7;
          m_mc++;
          if (m_mc == LOCK_CNT) begin m_st = 2; m_wc = 0; m_we = 0; end
        end else begin
          m_mc = 0; m_st = 0;
        end
        default: begin
          m_idx = (m_idx + 1) % 7;
          m_wc++;
          if (b != expb) begin
            be = 1'b1;
            m_we++;
            if (m_ec != '1) m_ec = m_ec + 1'b1;
          end
          if (m_we == ERR_THRESH) begin
            m_st = 0; m_mc = 0; ll = 1'b1;
          end else if (m_wc == ERR_WINDOW) begin
            m_wc = 0; m_we = 0;
          end
        end
      endcase
    end
    if (clr) m_ec = '0;
    e.lk = (m_st == 2);
    e.be = be;
    e.ll = ll;
    e.ec = m_ec;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic inv, input logic clr);
    logic b;
    b = seqb[gen_idx] ^ inv;
    gen_idx = (gen_idx + 1) % 7;
    cyc(1'b1, b, clr);
  endtask

  task automatic idle(input logic clr);
    cyc(1'b0, 1'($urandom_range(0, 1)), clr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clear_cnt = 1'b0;
    mdl_reset();
    gen_idx = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clear_cnt = 1'b0;
    mdl_reset();
    gen_idx = 0;
    #3;
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL rst_locked got=%b exp=0", locked); end
    checks++;
    if (bit_err !== 1'b0) begin failures++; $display("FAIL rst_bit_err got=%b exp=0", bit_err); end
    checks++;
    if (lock_lost !== 1'b0) begin failures++; $display("FAIL rst_lock_lost got=%b exp=0", lock_lost); end
    checks++;
    if (err_count !== '0) begin failures++; $display("FAIL rst_err_count got=%0d exp=0", err_count); end
    @(negedge clk);
    reset = 1'b1;
    idle(1'b0);
    idle(1'b0);
  endtask

  task automatic test_aligned();
    do_reset();
    for (int i = 1; i <= 1000; i++) begin
      send(1'b0, 1'b0);
      if (i == LOCK_CNT - 1) begin
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL aligned_early got=%b exp=0", locked); end
      end
      if (i == LOCK_CNT) begin
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL aligned_lock got=%b exp=1", locked); end
      end
    end
    checks++;
    if (err_count !== '0) begin failures++; $display("FAIL aligned_errs got=%0d exp=0", err_count); end
  endtask

  task automatic test_offset();
    int lock_at;
    int errs;
    lock_at = -1;
    errs = 0;
    do_reset();
    gen_idx = 3;
    for (int i = 1; i <= 64; i++) begin
      send(1'b0, 1'b0);
      if (bit_err === 1'b1) errs++;
      if (lock_at < 0 && locked === 1'b1) lock_at = i;
    end
    checks++;
    if (lock_at < LOCK_CNT) begin failures++; $display("FAIL offset_lock got=%0d exp=8..64", lock_at); end
    checks++;
    if (errs != 0) begin failures++; $display("FAIL offset_bit_err got=%0d exp=0", errs); end
    checks++;
    if (err_count !== '0) begin failures++; $display("FAIL offset_errs got=%0d exp=0", err_count); end
  endtask

  task automatic test_single_err();
    do_reset();
    for (int i = 0; i < LOCK_CNT + 10; i++) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    checks++;
    if (bit_err !== 1'b1) begin failures++; $display("FAIL single_pulse got=%b exp=1", bit_err); end
    send(1'b0, 1'b0);
    checks++;
    if (bit_err !== 1'b0) begin failures++; $display("FAIL single_pulse_end got=%b exp=0", bit_err); end
    checks++;
    if (err_count !== 16'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", err_count); end
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL single_locked got=%b exp=1", locked); end
  endtask

  task automatic test_loss();
    int drops;
    do_reset();
    for (int i = 0; i < LOCK_CNT; i++) send(1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      send(i == 5 || i == 10 || i == 15 || i == 20, 1'b0);
      if (i == 20) begin
        checks++;
        if (lock_lost !== 1'b1) begin failures++; $display("FAIL loss_pulse got=%b exp=1", lock_lost); end
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL loss_locked got=%b exp=0", locked); end
        checks++;
        if (err_count !== 16'd4) begin failures++; $display("FAIL loss_count got=%0d exp=4", err_count); end
      end
    end
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL loss_relock got=%b exp=1", locked); end

    // Three errors per window, then two either side of a window boundary.
    drops = 0;
    do_reset();
    for (int i = 0; i < LOCK_CNT; i++) send(1'b0, 1'b0);
    for (int w = 0; w < 5; w++) begin
      for (int i = 0; i < ERR_WINDOW; i++) begin
        if (w < 3) send(i == 3 || i == 20 || i == 40, 1'b0);
        else if (w == 3) send(i == 62 || i == 63, 1'b0);
        else send(i == 0 || i == 1, 1'b0);
        if (locked !== 1'b1) drops++;
      end
    end
    checks++;
    if (drops != 0) begin failures++; $display("FAIL window_drops got=%0d exp=0", drops); end
    checks++;
    if (err_count !== 16'd13) begin failures++; $display("FAIL window_count got=%0d exp=13", err_count); end
  endtask

  task automatic test_sparse_valid();
    int vcount;
    int lock_at;
    vcount = 0;
    lock_at = -1;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      if (c % 3 == 0) begin
        send(1'b0, 1'b0);
        vcount++;
        if (lock_at < 0 && locked === 1'b1) lock_at = vcount;
      end else begin
        idle(1'b0);
      end
    end
    checks++;
    if (lock_at != LOCK_CNT) begin failures++; $display("FAIL sparse_lock got=%0d exp=8", lock_at); end
    send(1'b1, 1'b1);
    checks++;
    if (bit_err !== 1'b1) begin failures++; $display("FAIL clr_pulse got=%b exp=1", bit_err); end
    checks++;
    if (err_count !== '0) begin failures++; $display("FAIL clr_priority got=%0d exp=0", err_count); end
    idle(1'b0);
    send(1'b1, 1'b0);
    idle(1'b0);
    checks++;
    if (bit_err !== 1'b0) begin failures++; $display("FAIL idle_bit_err got=%b exp=0", bit_err); end
    checks++;
    if (err_count !== 16'd1) begin failures++; $display("FAIL idle_count got=%0d exp=1", err_count); end
    idle(1'b1);
    checks++;
    if (err_count !== '0) begin failures++; $display("FAIL idle_clear got=%0d exp=0", err_count); end
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL clr_locked got=%b exp=1", locked); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < LOCK_CNT; i++) send(1'b0, 1'b0);
    for (int i = 0; i < 150; i++) send(i % 30 == 0, 1'b0);
    checks++;
    if (err_count !== 16'd5) begin failures++; $display("FAIL pre_rst_count got=%0d exp=5", err_count); end
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL pre_rst_locked got=%b exp=1", locked); end
    #1;
    reset = 1'b0;
    bit_valid = 1'b0;
    clear_cnt = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL async_locked got=%b exp=0", locked); end
    checks++;
    if (err_count !== '0) begin failures++; $display("FAIL async_count got=%0d exp=0", err_count); end
    mdl_reset();
    gen_idx = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < LOCK_CNT; i++) send(1'b0, 1'b0);
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL async_relock got=%b exp=1", locked); end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_offset();
    test_single_err();
    test_loss();
    test_sparse_valid();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
